// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Upstream feeder of the instruction decoder. Walks a program counter
// through program memory, hides the one-cycle memory read latency behind a
// small first-word-fall-through prefetch FIFO, honours consumer
// back-pressure, and accepts PC redirects from the loop-control logic.
// A redirect flushes every prefetched word. A one-bit epoch tags each
// outstanding read so that a response issued before a redirect is never
// pushed after it.
//
// Ports:
//   clk             clock
//   reset           synchronous, active-high reset
//   start           pulse: begin fetching at PC 0 (accepted in IDLE/DONE)
//   prog_len        number of instructions, sampled on accepted start
//   imem_en         program-memory read enable
//   imem_addr       program-memory read address
//   imem_rdata      read data, valid one cycle after imem_en
//   redirect_valid  pulse: resume fetching at redirect_pc
//   redirect_pc     redirect target
//   instr_out       instruction to decoder, bit 0 = opcode MSB
//   instr_pc        address of instr_out
//   instr_valid     instr_out valid
//   instr_ready     consumer accepts; transfer on valid && ready
//   busy            state is FETCH or DRAIN
//   done            high in DONE until next accepted start or reset
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int PC_WIDTH    = 10,
    parameter int FIFO_DEPTH  = 4,
    parameter int INSTR_WIDTH = 18
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [PC_WIDTH-1:0]    prog_len,
    output logic                   imem_en,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic [0:INSTR_WIDTH-1] instr_out,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Control state
    state_t              state;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] prog_len_q;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                epoch;

    // Outstanding read (response stage)
    logic                vld_p1;
    logic                epoch_p1;
    logic [PC_WIDTH-1:0] pc_p1;

    // Prefetch storage (data only, not reset)
    logic [INSTR_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]    pc_mem   [FIFO_DEPTH];

    // Decoded control
    logic               start_acc;
    logic               redir;
    logic               fifo_empty;
    logic [CNT_W:0]     occupancy;
    logic               issue;
    logic               push;
    logic               pop;

    // -----------------------------------------------------------------------
    // Issue / push / pop decisions
    // -----------------------------------------------------------------------
    always_comb begin
        start_acc  = start && ((state == S_IDLE) || (state == S_DONE));
        // start takes precedence; redirect has no meaning before the first start
        redir      = redirect_valid && (state != S_IDLE) && !start_acc;
        fifo_empty = (count == '0);

        // Reserve a slot for the read already in flight so a response
        // always finds room in the FIFO.
        occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1};
        issue      = (state == S_FETCH)
                     && (fetch_pc < prog_len_q)
                     && (occupancy < (CNT_W+1)'(FIFO_DEPTH))
                     && !redirect_valid;

        // A response belongs to the current stream only if its epoch still
        // matches and no redirect is flushing the FIFO at this edge.
        push       = vld_p1 && (epoch_p1 == epoch) && !redir;
        pop        = !fifo_empty && instr_ready;
    end

    assign imem_en   = issue;
    assign imem_addr = fetch_pc;

    // -----------------------------------------------------------------------
    // Output stage: head of FIFO, forced to zero when empty
    // -----------------------------------------------------------------------
    assign instr_valid = !fifo_empty;
    assign instr_out   = fifo_empty ? '0 : data_mem[rd_ptr];
    assign instr_pc    = fifo_empty ? '0 : pc_mem[rd_ptr];
    assign busy        = (state == S_FETCH) || (state == S_DRAIN);
    assign done        = (state == S_DONE);

    // -----------------------------------------------------------------------
    // p0 -> p1: capture the PC of the issued read
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (issue) begin
            pc_p1 <= fetch_pc;
        end
    end

    // -----------------------------------------------------------------------
    // p1 -> FIFO: write the returning word with its PC
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= pc_p1;
        end
    end

    // -----------------------------------------------------------------------
    // Control: FSM, fetch PC, FIFO pointers, in-flight tracking
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            fetch_pc   <= '0;
            prog_len_q <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            epoch      <= 1'b0;
            vld_p1     <= 1'b0;
            epoch_p1   <= 1'b0;
        end else begin
            vld_p1 <= issue;
            if (issue) begin
                epoch_p1 <= epoch;
            end

            if (start_acc) begin
                state      <= S_FETCH;
                fetch_pc   <= '0;
                prog_len_q <= prog_len;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
            end else if (redir) begin
                // Flush; a pop in this cycle has already been handed to the
                // consumer, so discarding the pointers loses nothing owed.
                epoch    <= ~epoch;
                fetch_pc <= redirect_pc;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                // A target at or beyond the end is treated as end of program.
                state    <= (redirect_pc < prog_len_q) ? S_FETCH : S_DRAIN;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + PC_WIDTH'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase

                case (state)
                    S_FETCH: begin
                        if (fetch_pc == prog_len_q) begin
                            state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (fifo_empty && !vld_p1) begin
                            state <= S_DONE;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule
